// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller and its MDU sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_t;

  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 32;
  localparam int DEF_CNT_W      = 32;

  // Down-counter width; never narrower than one bit even for single-cycle ops.
  function automatic int md_cnt_width(input int mul_cycles, input int div_cycles);
    int m;
    m = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hazard_md_seq.sv
// MDU sequencer: IDLE -> RUN (N cycles) -> DONE (1 cycle) -> IDLE.
module md_seq
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  md_op_t    op,
  output logic      busy,
  output logic      done,
  output md_state_t state
);

  localparam int CW = md_cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  md_state_t     state_r;
  logic [CW-1:0] cnt_r;

  // FSM and down-counter; a taken branch has no effect here since the running op is correct-path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
            cnt_r   <= (op == MD_DIV) ? DIV_LOAD : MUL_LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (cnt_r == '0) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign state = state_r;
  assign busy  = (state_r != IDLE);
  assign done  = (state_r == DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / MDU stalls, taken-branch flushes, perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [1:0]       id_md_op,
  input  logic             id_hilo_rd,
  input  logic             ex_mem_rd,
  input  logic [4:0]       ex_rd,
  input  logic             ex_br_taken,
  output logic             pc_wr,
  output logic             if_id_wr,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  md_state_t        md_state_s;
  logic             is_md_s;
  logic             load_use_s;
  logic             md_hazard_s;
  logic             stall_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  assign is_md_s    = (id_md_op == 2'b01) || (id_md_op == 2'b10);
  assign load_use_s = ex_mem_rd && (ex_rd != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  // HI/LO is only written at the end of DONE, so DONE still blocks readers.
  assign md_hazard_s = (id_hilo_rd || is_md_s) && (md_state_s != IDLE);
  assign stall_s     = load_use_s || md_hazard_s;

  // Priority: reset, then taken branch (ID is wrong-path), then stall, then normal flow.
  always_comb begin
    pc_wr       = 1'b1;
    if_id_wr    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    md_start    = 1'b0;
    if (rst) begin
      pc_wr       = 1'b0;
      if_id_wr    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_br_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall_s) begin
      pc_wr       = 1'b0;
      if_id_wr    = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      md_start = is_md_s;
    end
  end

  md_seq #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md_seq (
    .clk  (clk),
    .rst  (rst),
    .start(md_start),
    .op   (md_op_t'(id_md_op)),
    .busy (md_busy),
    .done (md_done),
    .state(md_state_s)
  );

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_s && !ex_br_taken && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (ex_br_taken && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic against a cycle-count model.
module tb_hazard_ctrl;

  localparam int MULN = 4;
  localparam int DIVN = 32;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs = 5'd0, id_rt = 5'd0, ex_rd = 5'd0;
  logic          id_use_rs = 1'b0, id_use_rt = 1'b0, id_hilo_rd = 1'b0;
  logic [1:0]    id_md_op = 2'b00;
  logic          ex_mem_rd = 1'b0, ex_br_taken = 1'b0;
  logic          pc_wr, if_id_wr, if_id_flush, id_ex_flush, md_start, md_busy, md_done;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_md_op(id_md_op), .id_hilo_rd(id_hilo_rd),
    .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .pc_wr(pc_wr), .if_id_wr(if_id_wr), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .md_start(md_start), .md_busy(md_busy),
    .md_done(md_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    logic [14:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: MDU occupancy as an absolute cycle window, counters as saturating integers.
  int  cyc      = 0;
  bit  m_active = 1'b0;
  int  m_start  = 0;
  int  m_end    = 0;
  int  m_stall  = 0;
  int  m_flush  = 0;

  task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [1:0] op, input logic hilo,
                      input logic exld, input logic [4:0] exrd, input logic br);
    bit busy, done, is_md, lu, st, start;
    bit [4:0] ctl;
    exp_t e;
    @(negedge clk);
    rst = r; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_md_op = op; id_hilo_rd = hilo; ex_mem_rd = exld; ex_rd = exrd; ex_br_taken = br;
    if (r) begin
      m_active = 1'b0; m_stall = 0; m_flush = 0;
    end
    busy  = m_active && (cyc > m_start) && (cyc <= m_end);
    done  = busy && (cyc == m_end);
    is_md = (op == 2'b01) || (op == 2'b10);
    lu    = exld && (exrd != 5'd0) && ((urs && rs == exrd) || (urt && rt == exrd));
    st    = lu || ((hilo || is_md) && busy);
    start = 1'b0;
    if (r)       ctl = 5'b00110;
    else if (br) ctl = 5'b11110;
    else if (st) ctl = 5'b00010;
    else begin
      start = is_md;
      ctl   = {4'b1100, start};
    end
    e.cyc = cyc;
    e.tag = tag;
    e.v   = {ctl, busy, done, CW'(m_stall), CW'(m_flush)};
    exp_q.push_back(e);
    if (start) begin
      m_active = 1'b1;
      m_start  = cyc;
      m_end    = cyc + ((op == 2'b10) ? DIVN : MULN) + 1;
    end
    if (!r) begin
      if (st && !br && m_stall < (1 << CW) - 1) m_stall++;
      if (br && m_flush < (1 << CW) - 1) m_flush++;
    end
    if (m_active && cyc >= m_end) m_active = 1'b0;
    cyc++;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic reset_n(input int n);
    for (int i = 0; i < n; i++) step("reset", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, so compare one queued expectation per cycle mid-phase.
  initial begin
    exp_t e;
    logic [14:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_wr, if_id_wr, if_id_flush, id_ex_flush, md_start, md_busy, md_done, stall_cnt, flush_cnt};
        compared++;
        if (act !== e.v) begin
          mismatched++;
          $display("FAIL %s cyc=%0d got pc/ifid/iff/idf/st/busy/done=%b sc=%0d fc=%0d want %b sc=%0d fc=%0d",
                   e.tag, e.cyc, act[14:8], act[7:4], act[3:0], e.v[14:8], e.v[7:4], e.v[3:0]);
        end
      end
    end
  end

  initial begin
    reset_n(2);
    // load-use on r8, then the load moves on
    step("load_use", 1'b0, 5'd8, 5'd3, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 5'd8, 1'b0);
    step("load_use_after", 1'b0, 5'd8, 5'd3, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 5'd8, 1'b0);
    // r0 destination never hazards
    step("load_r0", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 5'd0, 1'b0);
    idle("idle", 2);
    // mult then mfhi held in ID
    reset_n(1);
    step("mult_issue", 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++) step("mfhi_wait", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0, 1'b0);
    idle("post_mult", 2);
    // load-use and taken branch together
    step("lu_vs_branch", 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd9, 1'b1);
    step("mult_vs_branch", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 5'd0, 1'b1);
    idle("idle", 1);
    // div interrupted by reset at RUN cycle 10, then a fresh div
    step("div_issue", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd0, 1'b0);
    idle("div_run", 10);
    reset_n(1);
    idle("after_rst", 1);
    step("div2_issue", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < DIVN + 2; i++) step("div2_mflo", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0, 1'b0);
    // saturate both counters
    reset_n(1);
    for (int i = 0; i < 18; i++) step("stall_sat", 1'b0, 5'd4, 5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd4, 1'b0);
    for (int i = 0; i < 18; i++) step("flush_sat", 1'b0, 5'd4, 5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd4, 1'b1);
    // random traffic
    reset_n(1);
    for (int i = 0; i < 600; i++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step("random", ($urandom_range(0, 99) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), op, ($urandom_range(0, 3) == 0), 1'($urandom),
           5'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0));
    end
    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
